// File: rtl/rr_arb_idx32.sv
// Round-robin arbiter over 32 level requesters. It emits the winning index as a registered
// 5-bit value for the downstream one-hot decoder. Define RR_LOCK_EN to enable burst grant locking.
module rr_arb_idx32 #(
  parameter int NUM_REQ = 32,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   ptr,
  input  logic               lock
);

  // Handshake: an index transfers on a rising edge when out_valid && out_ready are both high.
  // Once out_valid rises, out_idx, out_valid and ptr stay frozen until that transfer happens.
  // The output slot is free when it is empty or is being drained in this cycle.
  logic               slot_free;
  logic               any_req;
  logic               hi_any;
  logic               hold_lock;
  logic [NUM_REQ-1:0] mask_hi;
  logic [NUM_REQ-1:0] req_hi;
  logic [IDX_W-1:0]   idx_hi;
  logic [IDX_W-1:0]   idx_all;
  logic [IDX_W-1:0]   winner;

  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign any_req   = |req;

  // Double-range search. The upper half covers bits ptr..31. If that half has no request,
  // the search wraps to the lowest set bit of the whole vector.
  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_hi[i] = (IDX_W'(i) >= ptr);
    end
  end

  assign req_hi  = req & mask_hi;
  assign hi_any  = |req_hi;
  assign idx_hi  = first_set(req_hi);
  assign idx_all = first_set(req);
  assign winner  = hi_any ? idx_hi : idx_all;

`ifdef RR_LOCK_EN
  // A locked burst re-grants the current owner while it still requests. The pointer does not move.
  assign hold_lock = out_valid && out_ready && lock && req[out_idx];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign hold_lock   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (slot_free) begin
      if (hold_lock) begin
        out_valid <= 1'b1;
      end else if (any_req) begin
        out_idx   <= winner;
        out_valid <= 1'b1;
        ptr       <= winner + IDX_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_idx32.sv
// Scoreboard bench for rr_arb_idx32. The driver pushes the expected grant order, and a monitor
// pops an entry on every accepted grant. The lock checks follow RR_LOCK_EN.
module tb_rr_arb_idx32;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  ptr;
  logic        lock;

  logic [4:0] exp_q[$];
  int         errors;
  int         checks;

  rr_arb_idx32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr),
    .lock      (lock)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] idx);
    exp_q.push_back(idx);
  endtask

  // Monitor: at each negedge it compares every grant that will be accepted on the next rising edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got %0d, expected none at %0t", out_idx, $time);
        end else begin
          e = exp_q.pop_front();
          check("grant_idx", {27'd0, out_idx}, {27'd0, e});
        end
      end
    end
  end

  // Driver
  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    lock = 1'b0;
    repeat (3) cycle();
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_idx", {27'd0, out_idx}, 32'd0);
    check("reset_ptr", {27'd0, ptr}, 32'd0);
    rst_n = 1'b1;

    // Rotation: all requesters active. The grant order is 0..31 and then 0, 1.
    req = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 34; i++) push(5'(i % 32));
    cycle();
    check("first_latency_valid", {31'd0, out_valid}, 32'd1);
    check("first_ptr", {27'd0, ptr}, 32'd1);
    for (int i = 1; i < 32; i++) cycle();
    check("ptr_wrap_at_31", {27'd0, ptr}, 32'd0);
    cycle();
    cycle();
    check("rot_ptr_end", {27'd0, ptr}, 32'd2);

    // Idle: with no requests, valid drops and out_idx and ptr hold.
    req = '0;
    cycle();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_ptr", {27'd0, ptr}, 32'd2);
    check("idle_idx_hold", {27'd0, out_idx}, 32'd1);

    // Move ptr to 30 with a single request on bit 29.
    req = 32'h1 << 29;
    push(5'd29);
    cycle();
    check("ptr_at_30", {27'd0, ptr}, 32'd30);

    // Sparse request pattern that wraps: expect grants 0, 3, 0.
    req = 32'h0000_0009;
    push(5'd0); push(5'd3); push(5'd0);
    cycle();
    check("sparse_ptr_a", {27'd0, ptr}, 32'd1);
    cycle();
    check("sparse_ptr_b", {27'd0, ptr}, 32'd4);
    cycle();
    check("sparse_ptr_c", {27'd0, ptr}, 32'd1);
    req = '0;
    cycle();
    check("sparse_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure: hold grant 5 while req[5] drops and req[7] rises.
    req = 32'h1 << 5;
    out_ready = 1'b0;
    push(5'd5);
    cycle();
    req = 32'h1 << 7;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_idx_held", {27'd0, out_idx}, 32'd5);
      check("bp_ptr_held", {27'd0, ptr}, 32'd6);
      cycle();
    end
    out_ready = 1'b1;
    push(5'd7);
    cycle();
    check("bp_next_ptr", {27'd0, ptr}, 32'd8);
    req = '0;
    cycle();
    check("bp_idle", {31'd0, out_valid}, 32'd0);

    // Lock burst starting at grant 1. Lock is held for 3 handshakes and then released.
    req = 32'h0000_0012;
    lock = 1'b1;
`ifdef RR_LOCK_EN
    push(5'd1); push(5'd1); push(5'd1); push(5'd4);
`else
    push(5'd1); push(5'd4); push(5'd1); push(5'd4);
`endif
    cycle();
    check("lock_first_ptr", {27'd0, ptr}, 32'd2);
    cycle();
    cycle();
    lock = 1'b0;
    cycle();
    check("lock_end_ptr", {27'd0, ptr}, 32'd5);
    req = '0;
    cycle();
    check("lock_idle", {31'd0, out_valid}, 32'd0);

    // Reset mid-transaction discards a pending grant.
    req = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    cycle();
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_idx", {27'd0, out_idx}, 32'd0);
    check("async_reset_ptr", {27'd0, ptr}, 32'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(5'd0);
    cycle();
    req = '0;
    cycle();
    check("post_reset_idle", {31'd0, out_valid}, 32'd0);
    check("post_reset_ptr", {27'd0, ptr}, 32'd1);

    repeat (3) cycle();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_idx32.md
Name: rr_arb_idx32

Overview:
- Round-robin arbiter sitting directly upstream of the 5-to-32 one-hot decoder.
- Selects one of 32 level-sensitive requesters and emits the winner as a registered 5-bit index over a valid/ready handshake.
- The decoder consumes this index to generate the one-hot grant/select vector.
- Rotating priority pointer guarantees starvation-free service.

Parameters:
- NUM_REQ, 32, number of requesters; fixed at 32 for decoder compatibility (other values unsupported).
- IDX_W, 5, index width; must equal log2(NUM_REQ).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  32  level request vector; bit i = requester i wants service.
- out_idx  output  5  granted requester index; feeds decoder input.
- out_valid  output  1  out_idx holds a valid grant.
- out_ready  input  1  downstream accepts out_idx this cycle.
- ptr  output  5  current highest-priority index (status/debug).
- lock  input  1  hold-grant request; used only with RR_LOCK_EN, otherwise ignored.

Interface decision: one clock; reset is asynchronous and active-low (ports clk, rst_n).

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_idx=0, ptr=0. Outputs hold these values until the first clk edge after release.
- Output slot is free when out_valid=0, or when out_valid=1 and out_ready=1 (handshake).
- Arbitration runs only when the slot is free. Winner = first set req bit scanning ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32).
- Winner found: on next edge, out_idx<=winner, out_valid<=1, ptr<=(winner+1) mod 32. Wrap: winner 31 gives ptr 0.
- Slot free and req==0: out_valid<=0; out_idx and ptr hold.
- out_valid=1 and out_ready=0: out_idx, out_valid, ptr held stable. req changes are ignored, including deassertion of the granted bit. A grant is never withdrawn once presented.
- Latency: req asserted in cycle t with the slot free gives out_valid=1 in cycle t+1.
- Back-to-back: with out_ready held at 1 and requests pending, one grant is issued per cycle (full throughput).
- Simultaneous handshake and new request: the handshake completes and the new arbitration uses the already-updated ptr and the current req. No bubble.
- A single active requester is granted every cycle while out_ready=1.
- out_idx is always in 0..31, so the decoder always sees a legal input. out_valid qualifies it.
- Reset mid-transaction: a pending unaccepted grant is discarded and priority restarts at index 0.
- Implementation: registered outputs; combinational rotate-and-priority-encode (double-width mask or rotate) feeding the output register. No combinational path from out_ready to out_idx.

Optional Feature:
- Macro: RR_LOCK_EN.
- Defined: if lock=1 during a handshake and req[out_idx] is still 1, the next grant is the same out_idx and ptr is not advanced. Used for multi-beat bursts. If req[out_idx]=0, normal arbitration runs.
- Undefined: lock port exists but is ignored; behaviour is pure round-robin.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with req=32'hFFFF_FFFF. Required: out_valid=0, out_idx=0, ptr=0 immediately, asynchronously.
- Rotation: req=32'hFFFF_FFFF, out_ready=1 for 34 cycles after reset. Required: out_idx=0,1,...,31,0,1 on consecutive cycles; ptr wraps 31 to 0.
- Sparse and wrap: ptr=30 reached, req=32'h0000_0009. Required: grant 0, then 3, then 0. ptr goes 1, 4, 1.
- Backpressure: grant idx 5 presented, out_ready=0 for 4 cycles while req[5] drops and req[7] rises. Required: out_idx=5 and out_valid=1 held. After out_ready=1, next out_idx=7.
- Idle: req=0 with out_ready=1. Required: out_valid=0 one cycle after the last handshake; ptr unchanged.
- RR_LOCK_EN: req=32'h0000_0012, lock=1 for 3 handshakes starting at grant 1. Required: out_idx=1,1,1. Then lock=0 gives 4.
